centroid_tracker: RTL and testbench
===================================

Name: centroid_tracker

Overview:
- Multi-channel successor to the single-target centre-of-mass unit.
- Accumulates coordinate sums, pixel count and bounding box per channel over one frame of masked pixels.
- On `calculate`, computes each channel's centroid with one shared serial divider and streams one result per channel.
- Sits between the per-pixel colour/threshold classifiers and the game-control logic; channels are, for example, player marker and obstacle markers.

Parameters:
- NUM_CH, 2, number of independent tracked channels (1..8).
- X_W, 11, pixel_x width.
- Y_W, 10, pixel_y width.
- CNT_W, 20, per-channel pixel counter width.
- MIN_PIXELS, 1, minimum count for a channel to be reported found (must be ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pixel_x  in  X_W  pixel column
- pixel_y  in  Y_W  pixel row
- pixel_valid  in  1  pixel qualifier
- pixel_mask  in  NUM_CH  bit c set = pixel belongs to channel c
- calculate  in  1  end-of-frame strobe
- busy  out  1  high while computing/streaming
- res_valid  out  1  one-cycle strobe per channel result
- res_ch  out  $clog2(NUM_CH) (min 1)  channel index of result
- res_found  out  1  count ≥ MIN_PIXELS and no overflow
- res_x  out  X_W  centroid x = floor(sum_x/count)
- res_y  out  Y_W  centroid y = floor(sum_y/count)
- res_count  out  CNT_W  pixel count
- res_min_x, res_max_x  out  X_W  bounding box x
- res_min_y, res_max_y  out  Y_W  bounding box y
- res_ovf  out  1  count saturated this frame
- done  out  1  one-cycle strobe after last channel result

Behaviour:
- Reset: all accumulators cleared, state ACCUM; busy, res_valid, done, res_found, res_ovf = 0; res_* data = 0; min regs = all-ones, max regs = 0.
- Accumulator widths: sum_x is X_W+CNT_W bits, sum_y is Y_W+CNT_W bits, so sums cannot overflow.
- Count saturation: count saturates at 2^CNT_W−1 and sets that channel's ovf flag. Once saturated, sums and bbox stop updating for that channel.
- ACCUM state: each cycle with pixel_valid, for every channel c with pixel_mask[c]=1:
  - count+=1, sum_x+=pixel_x, sum_y+=pixel_y;
  - min/max updated.
  - Zero mask bits mean no update.
- calculate in ACCUM:
  - If pixel_valid is high in the same cycle, that pixel is accumulated first.
  - Next cycle, state goes to CALC with ch=0 and busy=1.
- calculate while busy is ignored. pixel_valid while busy is ignored (pixels dropped).
- Per channel, in order 0..NUM_CH−1:
  - CHECK (1 cycle): if count < MIN_PIXELS or ovf → go to OUT with found=0, x=y=0. Otherwise → DIV_X.
  - DIV_X: restoring divide of sum_x by count, 1 quotient bit/cycle, exactly X_W+CNT_W cycles. Quotient low X_W bits → res_x.
  - DIV_Y: same for sum_y, exactly Y_W+CNT_W cycles.
  - OUT (1 cycle): res_valid=1 with all res_* fields for ch; channel accumulators cleared. Then ch+1 → CHECK, or after the last channel → FIN.
- Latency:
  - Found channel: 2+(X_W+CNT_W)+(Y_W+CNT_W) cycles from CHECK entry to res_valid.
  - Not-found channel: res_valid 1 cycle after CHECK.
- res_* data hold their values until the next res_valid.
- FIN (1 cycle): done=1, busy=0, return to ACCUM. Pixels are accepted again from the cycle after FIN.
- Divide by zero is impossible, since MIN_PIXELS≥1 gates DIV entry.
- rst mid-CALC: computation is abandoned, no res_valid/done is issued, and all state returns to reset values next cycle.

Test Plan:
- Single pixel (x=100,y=50) on ch0 only, calculate → ch0: found=1, x=100, y=50, count=1, bbox 100..100/50..50; ch1: found=0, count=0. done exactly 1 cycle after ch1 result.
- ch0 pixels (10,20),(13,21),(20,30), ch1 pixel (639,479) with mask=2'b11 on the last one → ch0: count=4, x=170 (682/4), y=137 (550/4), bbox 10..639/20..479; ch1: x=639, y=479, count=1.
- MIN_PIXELS=3, ch0 gets 2 pixels → res_found=0, res_x=0, res_count=2, and res_valid arrives 1 cycle after CHECK (no divide cycles).
- calculate coincident with final pixel_valid (x=7,y=9) → that pixel is included in the count. A second calculate plus pixels while busy → ignored; the next frame's sums start from zero.
- CNT_W=4: 17 pixels on ch0 → count=15, res_ovf=1, res_found=0.
- rst asserted mid-DIV_Y of ch0 → no res_valid/done. A following frame with one pixel (5,5) yields x=5, y=5, count=1.

Source files
------------

// File: rtl/centroid_tracker.sv
// centroid_tracker: per-channel pixel count, coordinate sums and bounding box over one frame of masked pixels.
// On calculate, each channel's centroid comes out of one shared restoring divider, one result per channel.
// A found channel takes 2+(X_W+CNT_W)+(Y_W+CNT_W) cycles from CHECK to res_valid; a not-found channel takes 1.
module centroid_tracker #(
  parameter int NUM_CH     = 2,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [X_W-1:0]    pixel_x,
  input  logic [Y_W-1:0]    pixel_y,
  input  logic              pixel_valid,
  input  logic [NUM_CH-1:0] pixel_mask,
  input  logic              calculate,
  output logic              busy,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic              res_found,
  output logic [X_W-1:0]    res_x,
  output logic [Y_W-1:0]    res_y,
  output logic [CNT_W-1:0]  res_count,
  output logic [X_W-1:0]    res_min_x,
  output logic [X_W-1:0]    res_max_x,
  output logic [Y_W-1:0]    res_min_y,
  output logic [Y_W-1:0]    res_max_y,
  output logic              res_ovf,
  output logic              done
);

  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;
  localparam int DW   = (SX_W > SY_W) ? SX_W : SY_W;
  localparam int BC_W = $clog2(DW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_ACCUM, S_CHECK, S_DIV_X, S_DIV_Y, S_DIV_END, S_OUT, S_FIN
  } state_t;

  state_t state, state_nxt;

  // per-channel frame accumulators
  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [SX_W-1:0]  sum_x [NUM_CH];
  logic [SY_W-1:0]  sum_y [NUM_CH];
  logic [X_W-1:0]   min_x [NUM_CH];
  logic [X_W-1:0]   max_x [NUM_CH];
  logic [Y_W-1:0]   min_y [NUM_CH];
  logic [Y_W-1:0]   max_y [NUM_CH];
  logic             ovf   [NUM_CH];

  // channel under calculation and shared divider state
  logic [CH_W-1:0]  ch;
  logic [DW-1:0]    dvd, dvd_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [CNT_W:0]   trial;
  logic             ge;
  logic [BC_W-1:0]  bcnt;
  logic [X_W-1:0]   qx;
  logic             not_found;
  logic             res_load;

  logic [CNT_W-1:0] cur_cnt;
  logic [SX_W-1:0]  cur_sx;
  logic [SY_W-1:0]  cur_sy;
  logic             cur_ovf;

  assign cur_cnt = cnt[ch];
  assign cur_sx  = sum_x[ch];
  assign cur_sy  = sum_y[ch];
  assign cur_ovf = ovf[ch];

  // channel qualifies for division only with enough pixels and a trustworthy (unsaturated) count
  always_comb begin
    not_found = (cur_cnt < MIN_CNT) || cur_ovf;
    res_load  = ((state == S_CHECK) && not_found) || (state == S_DIV_END);
  end

  // one restoring-division step: shift the next dividend bit into the remainder, subtract if it fits
  always_comb begin
    trial   = {rem, dvd[DW-1]};
    ge      = (trial >= {1'b0, cur_cnt});
    rem_nxt = ge ? (trial[CNT_W-1:0] - cur_cnt) : trial[CNT_W-1:0];
    dvd_nxt = {dvd[DW-2:0], ge};
  end

  // accumulate masked pixels while idle; a channel is cleared in the cycle its result is presented
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]   <= '0;
        sum_x[c] <= '0;
        sum_y[c] <= '0;
        min_x[c] <= '1;
        max_x[c] <= '0;
        min_y[c] <= '1;
        max_y[c] <= '0;
        ovf[c]   <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((state == S_OUT) && (ch == CH_W'(c))) begin
          cnt[c]   <= '0;
          sum_x[c] <= '0;
          sum_y[c] <= '0;
          min_x[c] <= '1;
          max_x[c] <= '0;
          min_y[c] <= '1;
          max_y[c] <= '0;
          ovf[c]   <= 1'b0;
        end else if ((state == S_ACCUM) && pixel_valid && pixel_mask[c]) begin
          // a saturated channel freezes so its sums stay consistent with its count
          if (cnt[c] == CNT_MAX) begin
            ovf[c] <= 1'b1;
          end else begin
            cnt[c]   <= cnt[c] + CNT_W'(1);
            sum_x[c] <= sum_x[c] + SX_W'(pixel_x);
            sum_y[c] <= sum_y[c] + SY_W'(pixel_y);
            if (pixel_x < min_x[c]) min_x[c] <= pixel_x;
            if (pixel_x > max_x[c]) max_x[c] <= pixel_x;
            if (pixel_y < min_y[c]) min_y[c] <= pixel_y;
            if (pixel_y > max_y[c]) max_y[c] <= pixel_y;
          end
        end
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_ACCUM;
    else     state <= state_nxt;
  end

  // next-state logic: walk channels in order, dividing only those that qualify
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACCUM:   if (calculate) state_nxt = S_CHECK;
      S_CHECK:   state_nxt = not_found ? S_OUT : S_DIV_X;
      S_DIV_X:   if (bcnt == BC_W'(1)) state_nxt = S_DIV_Y;
      S_DIV_Y:   if (bcnt == BC_W'(1)) state_nxt = S_DIV_END;
      S_DIV_END: state_nxt = S_OUT;
      S_OUT:     state_nxt = (ch == LAST_CH) ? S_FIN : S_CHECK;
      S_FIN:     state_nxt = S_ACCUM;
      default:   state_nxt = S_ACCUM;
    endcase
  end

  // outputs decoded from state; result data are registered separately and held
  always_comb begin
    busy      = (state != S_ACCUM) && (state != S_FIN);
    res_valid = (state == S_OUT);
    done      = (state == S_FIN);
  end

  // divider sequencing, channel index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ch        <= '0;
      dvd       <= '0;
      rem       <= '0;
      bcnt      <= '0;
      qx        <= '0;
      res_ch    <= '0;
      res_found <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      res_count <= '0;
      res_min_x <= '0;
      res_max_x <= '0;
      res_min_y <= '0;
      res_max_y <= '0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        S_ACCUM: if (calculate) ch <= '0;
        S_CHECK: begin
          // dividend left-aligned so the quotient accumulates in the low bits
          dvd  <= DW'(cur_sx) << (DW - SX_W);
          rem  <= '0;
          bcnt <= BC_W'(SX_W);
        end
        S_DIV_X: begin
          if (bcnt == BC_W'(1)) begin
            qx   <= dvd_nxt[X_W-1:0];
            dvd  <= DW'(cur_sy) << (DW - SY_W);
            rem  <= '0;
            bcnt <= BC_W'(SY_W);
          end else begin
            dvd  <= dvd_nxt;
            rem  <= rem_nxt;
            bcnt <= bcnt - BC_W'(1);
          end
        end
        S_DIV_Y: begin
          dvd  <= dvd_nxt;
          rem  <= rem_nxt;
          bcnt <= bcnt - BC_W'(1);
        end
        S_OUT:   ch <= ch + CH_W'(1);
        default: ;
      endcase

      if (res_load) begin
        res_ch    <= ch;
        res_found <= (state == S_DIV_END);
        res_x     <= (state == S_DIV_END) ? qx : '0;
        res_y     <= (state == S_DIV_END) ? dvd[Y_W-1:0] : '0;
        res_count <= cur_cnt;
        res_min_x <= min_x[ch];
        res_max_x <= max_x[ch];
        res_min_y <= min_y[ch];
        res_max_y <= max_y[ch];
        res_ovf   <= cur_ovf;
      end
    end
  end

endmodule

// File: tb/tb_centroid_tracker.sv
// tb_centroid_tracker: three centroid_tracker instances (default, MIN_PIXELS=3, CNT_W=4) share one stimulus stream.
// A per-instance model pushes expected results with their arrival cycle; monitors pop and compare on negedge.
// busy is compared every cycle against the modelled busy window.
`timescale 1ns/1ps
module tb_centroid_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic [1:0]  pixel_mask;
  logic        calculate;

  logic [2:0]  busy, rv, dn, fnd, ovf;
  logic        rch   [3];
  logic [10:0] rx    [3];
  logic [10:0] rminx [3];
  logic [10:0] rmaxx [3];
  logic [9:0]  ry    [3];
  logic [9:0]  rminy [3];
  logic [9:0]  rmaxy [3];
  logic [19:0] rc0, rc1;
  logic [3:0]  rc2;

  centroid_tracker u_dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_mask(pixel_mask), .calculate(calculate), .busy(busy[0]), .res_valid(rv[0]),
    .res_ch(rch[0]), .res_found(fnd[0]), .res_x(rx[0]), .res_y(ry[0]), .res_count(rc0),
    .res_min_x(rminx[0]), .res_max_x(rmaxx[0]), .res_min_y(rminy[0]), .res_max_y(rmaxy[0]),
    .res_ovf(ovf[0]), .done(dn[0])
  );

  centroid_tracker #(.MIN_PIXELS(3)) u_min (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_mask(pixel_mask), .calculate(calculate), .busy(busy[1]), .res_valid(rv[1]),
    .res_ch(rch[1]), .res_found(fnd[1]), .res_x(rx[1]), .res_y(ry[1]), .res_count(rc1),
    .res_min_x(rminx[1]), .res_max_x(rmaxx[1]), .res_min_y(rminy[1]), .res_max_y(rmaxy[1]),
    .res_ovf(ovf[1]), .done(dn[1])
  );

  centroid_tracker #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_mask(pixel_mask), .calculate(calculate), .busy(busy[2]), .res_valid(rv[2]),
    .res_ch(rch[2]), .res_found(fnd[2]), .res_x(rx[2]), .res_y(ry[2]), .res_count(rc2),
    .res_min_x(rminx[2]), .res_max_x(rmaxx[2]), .res_min_y(rminy[2]), .res_max_y(rmaxy[2]),
    .res_ovf(ovf[2]), .done(dn[2])
  );

  typedef struct {
    int     ch;
    bit     found;
    longint x, y, cnt, minx, maxx, miny, maxy;
    bit     ovf;
    int     cyc;
  } exp_t;

  exp_t   sbq [3][$];
  int     dq  [3][$];
  longint m_cnt [3][2];
  longint m_sx  [3][2];
  longint m_sy  [3][2];
  longint m_minx[3][2];
  longint m_maxx[3][2];
  longint m_miny[3][2];
  longint m_maxy[3][2];
  bit     m_ovf [3][2];
  int     m_lo  [3];
  int     m_hi  [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_q = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cntw(input int k);
    return (k == 2) ? 4 : 20;
  endfunction

  function automatic int minpx(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_clear(input int k, input int c);
    m_cnt[k][c]  = 0;
    m_sx[k][c]   = 0;
    m_sy[k][c]   = 0;
    m_minx[k][c] = 2047;
    m_maxx[k][c] = 0;
    m_miny[k][c] = 1023;
    m_maxy[k][c] = 0;
    m_ovf[k][c]  = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2; c++) model_clear(k, c);
      sbq[k].delete();
      dq[k].delete();
      m_lo[k] = 1;
      m_hi[k] = 0;
    end
  endtask

  task automatic model_pix(input int k, input int c, input int x, input int y);
    if (m_cnt[k][c] == (longint'(1) << cntw(k)) - 1) begin
      m_ovf[k][c] = 1'b1;
    end else begin
      m_cnt[k][c]++;
      m_sx[k][c] += x;
      m_sy[k][c] += y;
      if (x < m_minx[k][c]) m_minx[k][c] = x;
      if (x > m_maxx[k][c]) m_maxx[k][c] = x;
      if (y < m_miny[k][c]) m_miny[k][c] = y;
      if (y > m_maxy[k][c]) m_maxy[k][c] = y;
    end
  endtask

  // calculate sampled at the edge after cycle p: CHECK for ch0 is visible in cycle p+1
  task automatic push_frame(input int k, input int p);
    int   cur;
    int   rc;
    int   cw;
    bit   nf;
    exp_t e;
    cur = p + 1;
    cw  = cntw(k);
    for (int c = 0; c < 2; c++) begin
      nf      = (m_cnt[k][c] < minpx(k)) || m_ovf[k][c];
      rc      = nf ? cur + 1 : cur + 2 + (11 + cw) + (10 + cw);
      e.ch    = c;
      e.found = !nf;
      e.x     = nf ? 0 : m_sx[k][c] / m_cnt[k][c];
      e.y     = nf ? 0 : m_sy[k][c] / m_cnt[k][c];
      e.cnt   = m_cnt[k][c];
      e.minx  = m_minx[k][c];
      e.maxx  = m_maxx[k][c];
      e.miny  = m_miny[k][c];
      e.maxy  = m_maxy[k][c];
      e.ovf   = m_ovf[k][c];
      e.cyc   = rc;
      sbq[k].push_back(e);
      model_clear(k, c);
      cur = rc + 1;
    end
    dq[k].push_back(cur);
    m_lo[k] = p + 1;
    m_hi[k] = cur;
  endtask

  task automatic drive(input int x, input int y, input bit v, input bit [1:0] m, input bit calc);
    int q;
    @(posedge clk);
    #1;
    pixel_x     = x[10:0];
    pixel_y     = y[9:0];
    pixel_valid = v;
    pixel_mask  = m;
    calculate   = calc;
    q           = cyc;
    last_q      = q;
    for (int k = 0; k < 3; k++) begin
      if (!(q >= m_lo[k] && q <= m_hi[k])) begin
        if (v) begin
          for (int c = 0; c < 2; c++) if (m[c]) model_pix(k, c, x, y);
        end
        if (calc) push_frame(k, q);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 2'b00, 1'b0);
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int k = 0; k < 3; k++) if (sbq[k].size() != 0 || dq[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 3000 && pending(); i++) idle(1);
    idle(2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    pixel_valid = 1'b0;
    calculate   = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic mon(input int k);
    exp_t   e;
    int     d;
    longint rcv;
    rcv = (k == 0) ? longint'(rc0) : (k == 1) ? longint'(rc1) : longint'(rc2);
    chk($sformatf("u%0d_busy@%0d", k, cyc), busy[k], (cyc >= m_lo[k] && cyc < m_hi[k]));
    if (rv[k] === 1'b1) begin
      if (sbq[k].size() == 0) begin
        chk($sformatf("u%0d_unexpected_res", k), 1, 0);
      end else begin
        e = sbq[k].pop_front();
        chk($sformatf("u%0d_res_cyc", k), cyc, e.cyc);
        chk($sformatf("u%0d_ch", k), rch[k], e.ch);
        chk($sformatf("u%0d_ch%0d_found", k, e.ch), fnd[k], e.found);
        chk($sformatf("u%0d_ch%0d_x", k, e.ch), rx[k], e.x);
        chk($sformatf("u%0d_ch%0d_y", k, e.ch), ry[k], e.y);
        chk($sformatf("u%0d_ch%0d_count", k, e.ch), rcv, e.cnt);
        chk($sformatf("u%0d_ch%0d_min_x", k, e.ch), rminx[k], e.minx);
        chk($sformatf("u%0d_ch%0d_max_x", k, e.ch), rmaxx[k], e.maxx);
        chk($sformatf("u%0d_ch%0d_min_y", k, e.ch), rminy[k], e.miny);
        chk($sformatf("u%0d_ch%0d_max_y", k, e.ch), rmaxy[k], e.maxy);
        chk($sformatf("u%0d_ch%0d_ovf", k, e.ch), ovf[k], e.ovf);
      end
    end
    if (dn[k] === 1'b1) begin
      if (dq[k].size() == 0) begin
        chk($sformatf("u%0d_unexpected_done", k), 1, 0);
      end else begin
        d = dq[k].pop_front();
        chk($sformatf("u%0d_done_cyc", k), cyc, d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) mon(k);
    end
  end

  initial begin
    int p;
    rst         = 1'b1;
    pixel_x     = '0;
    pixel_y     = '0;
    pixel_valid = 1'b0;
    pixel_mask  = '0;
    calculate   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  busy[0], 0);
    chk("rst_valid", rv[0], 0);
    chk("rst_done",  dn[0], 0);
    chk("rst_found", fnd[0], 0);
    chk("rst_ovf",   ovf[0], 0);
    chk("rst_x",     rx[0], 0);
    chk("rst_y",     ry[0], 0);
    chk("rst_count", rc0, 0);
    chk("rst_ch",    rch[0], 0);
    chk("rst_max_x", rmaxx[0], 0);
    chk("rst_sat_count", rc2, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // single pixel on ch0; ch1 empty
    drive(100, 50, 1'b1, 2'b01, 1'b0);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    wait_drain();

    // several ch0 pixels, last one shared with ch1
    drive(10, 20, 1'b1, 2'b01, 1'b0);
    drive(13, 21, 1'b1, 2'b01, 1'b0);
    drive(20, 30, 1'b1, 2'b01, 1'b0);
    drive(639, 479, 1'b1, 2'b11, 1'b0);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    wait_drain();

    // ch0 below MIN_PIXELS=3 on u_min, ch1 at threshold
    drive(30, 40, 1'b1, 2'b01, 1'b0);
    drive(31, 41, 1'b1, 2'b01, 1'b0);
    drive(400, 300, 1'b1, 2'b10, 1'b0);
    drive(401, 301, 1'b1, 2'b10, 1'b0);
    drive(405, 310, 1'b1, 2'b10, 1'b0);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    wait_drain();

    // calculate coincident with the final pixel, then pixels and calculate while busy
    drive(1, 1, 1'b1, 2'b11, 1'b0);
    drive(7, 9, 1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) drive(50, 60, 1'b1, 2'b11, 1'b1);
    wait_drain();
    drive(8, 8, 1'b1, 2'b01, 1'b0);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    wait_drain();

    // 17 pixels on ch0: saturates the CNT_W=4 instance
    for (int i = 0; i < 17; i++) drive(3 + i, 4 + 2 * i, 1'b1, 2'b01, 1'b0);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    wait_drain();

    // random pixels over the full coordinate range
    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 2047), $urandom_range(0, 1023), 1'b1, 2'($urandom_range(0, 3)), 1'b0);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    wait_drain();

    // reset while u_dut is dividing y for ch0; nothing more may come out of it
    drive(200, 100, 1'b1, 2'b01, 1'b0);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    p = last_q;
    for (int i = 0; i < 100 && cyc < p + 40; i++) idle(1);
    do_reset();
    idle(150);
    drive(5, 5, 1'b1, 2'b01, 1'b0);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    wait_drain();

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_res_left", k), sbq[k].size(), 0);
      chk($sformatf("u%0d_done_left", k), dq[k].size(), 0);
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
